obstacle_scheduler: RTL and testbench

Owns the obstacle slot table that feeds `track_draw`. It sequences the per-frame position update: each frame it walks every slot, advances active obstacles toward the player by the current speed, and retires those that pass the player. Between scans it arbitrates spawn requests from `obstacle_generator` into the lowest free slot. It replaces the ad-hoc per-frame decrement in `top_level` and is the only writer of the obstacle table.

---
 rtl/obstacle_scheduler.sv | 156 +++++++++++++++
 tb/tb_obstacle_scheduler.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obstacle_scheduler.sv
// obstacle_scheduler: owns the obstacle slot table. Once per frame it walks
// every slot, moving active obstacles toward the player and retiring those
// that reach it; between scans it writes spawn requests into the lowest free slot.
module obstacle_scheduler #(
  parameter int          NUM_SLOTS = 10,
  parameter logic [10:0] SPAWN_POS = 11'd1023
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     game_reset_in,
  input  logic                     enable_in,
  input  logic                     frame_tick_in,
  input  logic [3:0]               speed_in,
  input  logic                     spawn_req_in,
  input  logic [1:0]               spawn_type_in,
  input  logic [1:0]               spawn_lane_in,
  output logic                     spawn_ack_out,
  output logic                     spawn_full_out,
  output logic                     update_busy_out,
  output logic                     frame_overrun_out,
  output logic [7:0]               retired_count_out,
  output logic [16*NUM_SLOTS-1:0]  obstacles_out
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    ACK
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [3:0]       speed_q;
  logic             pending_q;
  logic             ack_q;
  logic             full_q;
  logic             busy_q;
  logic             overrun_q;
  logic [7:0]       retired_q;
  logic [15:0]      slot_q [NUM_SLOTS];

  logic             free_found_d;
  logic [IDX_W-1:0] free_idx_d;
  logic [15:0]      cur_slot_d;
  logic [10:0]      cur_pos_d;
  logic [10:0]      speed_ext_d;
  logic             retire_d;
  logic [15:0]      scan_slot_d;
  logic             tick_ok_d;
  logic             last_idx_d;

  // Priority encoder: lowest-index slot whose active bit is clear.
  always_comb begin
    free_found_d = 1'b0;
    free_idx_d   = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_q[i][0]) begin
        free_found_d = 1'b1;
        free_idx_d   = IDX_W'(i);
      end
    end
  end

  // Next value of the slot under the scan index: retire, advance or keep.
  always_comb begin
    cur_slot_d  = slot_q[idx_q];
    cur_pos_d   = cur_slot_d[13:3];
    speed_ext_d = {7'b0, speed_q};
    retire_d    = cur_slot_d[0] && (speed_q != 4'd0) && (cur_pos_d <= speed_ext_d);
    tick_ok_d   = frame_tick_in && enable_in;
    last_idx_d  = (idx_q == IDX_W'(NUM_SLOTS - 1));
    if (retire_d) begin
      scan_slot_d = 16'b0;
    end else if (cur_slot_d[0]) begin
      scan_slot_d = {cur_slot_d[15:14], cur_pos_d - speed_ext_d, cur_slot_d[2:0]};
    end else begin
      scan_slot_d = cur_slot_d;
    end
  end

  // Scheduler FSM with the slot table, counters and all registered outputs.
  always_ff @(posedge clk_in) begin
    if (!rst_in || game_reset_in) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      speed_q   <= 4'd0;
      pending_q <= 1'b0;
      ack_q     <= 1'b0;
      full_q    <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      retired_q <= 8'd0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        slot_q[i] <= 16'b0;
      end
    end else begin
      full_q <= !free_found_d;
      ack_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if ((frame_tick_in || pending_q) && enable_in) begin
            speed_q   <= speed_in;
            idx_q     <= '0;
            pending_q <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= SCAN;
          end else if (spawn_req_in && enable_in && free_found_d) begin
            slot_q[free_idx_d] <= {spawn_type_in, SPAWN_POS, spawn_lane_in, 1'b1};
            ack_q              <= 1'b1;
            state_q            <= ACK;
          end
        end
        SCAN: begin
          slot_q[idx_q] <= scan_slot_d;
          if (retire_d && (retired_q != 8'hFF)) begin
            retired_q <= retired_q + 8'd1;
          end
          if (tick_ok_d) begin
            overrun_q <= 1'b1;
          end
          if (last_idx_d) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ACK: begin
          if (tick_ok_d) begin
            pending_q <= 1'b1;
          end
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  genvar g;
  generate
    for (g = 0; g < NUM_SLOTS; g++) begin : g_pack
      assign obstacles_out[16*g +: 16] = slot_q[g];
    end
  endgenerate

  assign spawn_ack_out     = ack_q;
  assign spawn_full_out    = full_q;
  assign update_busy_out   = busy_q;
  assign frame_overrun_out = overrun_q;
  assign retired_count_out = retired_q;

endmodule

// File: tb/tb_obstacle_scheduler.sv
// tb_obstacle_scheduler: directed scenarios for the obstacle scheduler with
// hand-computed expected slot contents, counters and handshake timing.
module tb_obstacle_scheduler;

  localparam int NUM_SLOTS = 10;

  logic                    clk_in = 1'b0;
  logic                    rst_in;
  logic                    game_reset_in;
  logic                    enable_in;
  logic                    frame_tick_in;
  logic [3:0]              speed_in;
  logic                    spawn_req_in;
  logic [1:0]              spawn_type_in;
  logic [1:0]              spawn_lane_in;
  logic                    spawn_ack_out;
  logic                    spawn_full_out;
  logic                    update_busy_out;
  logic                    frame_overrun_out;
  logic [7:0]              retired_count_out;
  logic [16*NUM_SLOTS-1:0] obstacles_out;

  int checks = 0;
  int errors = 0;

  obstacle_scheduler #(
    .NUM_SLOTS(NUM_SLOTS),
    .SPAWN_POS(11'd1023)
  ) dut (
    .clk_in           (clk_in),
    .rst_in           (rst_in),
    .game_reset_in    (game_reset_in),
    .enable_in        (enable_in),
    .frame_tick_in    (frame_tick_in),
    .speed_in         (speed_in),
    .spawn_req_in     (spawn_req_in),
    .spawn_type_in    (spawn_type_in),
    .spawn_lane_in    (spawn_lane_in),
    .spawn_ack_out    (spawn_ack_out),
    .spawn_full_out   (spawn_full_out),
    .update_busy_out  (update_busy_out),
    .frame_overrun_out(frame_overrun_out),
    .retired_count_out(retired_count_out),
    .obstacles_out    (obstacles_out)
  );

  // 10 ns clock
  always #5 clk_in = ~clk_in;

  // Advance one clock; outputs are settled 1 ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [15:0] slotOf(input int i);
    return obstacles_out[16*i +: 16];
  endfunction

  // Hold a spawn request until it is acked, then let the FSM return to IDLE.
  task automatic doSpawn(input logic [1:0] t, input logic [1:0] l, output bit ok);
    ok = 1'b0;
    spawn_type_in = t;
    spawn_lane_in = l;
    spawn_req_in  = 1'b1;
    for (int n = 0; n < 40; n++) begin
      step();
      if (spawn_ack_out) begin
        ok = 1'b1;
        break;
      end
    end
    spawn_req_in = 1'b0;
    step();
  endtask

  // One accepted tick followed by the full scan, ending back in IDLE.
  task automatic doTick(input logic [3:0] s);
    speed_in      = s;
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
    repeat (NUM_SLOTS) step();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) begin
      game_reset_in = 1'($urandom);
      enable_in     = 1'($urandom);
      frame_tick_in = 1'($urandom);
      speed_in      = 4'($urandom);
      spawn_req_in  = 1'($urandom);
      spawn_type_in = 2'($urandom);
      spawn_lane_in = 2'($urandom);
      step();
    end
    checks++;
    if (obstacles_out !== '0) begin
      errors++;
      $display("[TB] FAIL reset_table got %h want 0", obstacles_out);
    end
    checks++;
    if ({spawn_ack_out, spawn_full_out, update_busy_out, frame_overrun_out} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL reset_flags got %b want 0000",
               {spawn_ack_out, spawn_full_out, update_busy_out, frame_overrun_out});
    end
    checks++;
    if (retired_count_out !== 8'd0) begin
      errors++;
      $display("[TB] FAIL reset_count got %0d want 0", retired_count_out);
    end
    rst_in        = 1'b1;
    game_reset_in = 1'b0;
    enable_in     = 1'b1;
    frame_tick_in = 1'b0;
    speed_in      = 4'd0;
    spawn_req_in  = 1'b0;
    spawn_type_in = 2'd0;
    spawn_lane_in = 2'd0;
    step();
  endtask

  task automatic test_spawn();
    spawn_type_in = 2'd2;
    spawn_lane_in = 2'd1;
    spawn_req_in  = 1'b1;
    step();
    checks++;
    if (spawn_ack_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL spawn1_ack got %b want 1", spawn_ack_out);
    end
    checks++;
    if (slotOf(0) !== {2'b10, 11'd1023, 2'b01, 1'b1}) begin
      errors++;
      $display("[TB] FAIL spawn1_slot0 got %h want %h", slotOf(0), {2'b10, 11'd1023, 2'b01, 1'b1});
    end
    spawn_req_in = 1'b0;
    step();
    checks++;
    if (spawn_ack_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL spawn1_ack_pulse got %b want 0", spawn_ack_out);
    end
    spawn_type_in = 2'd0;
    spawn_lane_in = 2'd2;
    spawn_req_in  = 1'b1;
    step();
    spawn_req_in = 1'b0;
    checks++;
    if (spawn_ack_out !== 1'b1 || slotOf(1) !== {2'b00, 11'd1023, 2'b10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL spawn2_slot1 got ack %b slot %h want ack 1 slot %h",
               spawn_ack_out, slotOf(1), {2'b00, 11'd1023, 2'b10, 1'b1});
    end
    step();
  endtask

  task automatic test_scan();
    int  busyCount;
    bit  ackDuringBusy;
    speed_in      = 4'd5;
    frame_tick_in = 1'b1;
    spawn_type_in = 2'd3;
    spawn_lane_in = 2'd3;
    spawn_req_in  = 1'b1;
    step();
    frame_tick_in = 1'b0;
    busyCount     = 0;
    ackDuringBusy = 1'b0;
    for (int n = 0; n < 20; n++) begin
      if (!update_busy_out) break;
      busyCount++;
      if (spawn_ack_out) ackDuringBusy = 1'b1;
      step();
    end
    checks++;
    if (busyCount != NUM_SLOTS) begin
      errors++;
      $display("[TB] FAIL scan_busy_len got %0d want %0d", busyCount, NUM_SLOTS);
    end
    checks++;
    if (ackDuringBusy || spawn_ack_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL scan_no_early_ack got %b want 0", ackDuringBusy | spawn_ack_out);
    end
    checks++;
    if (slotOf(0) !== {2'b10, 11'd1018, 2'b01, 1'b1} || slotOf(1) !== {2'b00, 11'd1018, 2'b10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL scan_positions got %h %h want %h %h", slotOf(0), slotOf(1),
               {2'b10, 11'd1018, 2'b01, 1'b1}, {2'b00, 11'd1018, 2'b10, 1'b1});
    end
    step();
    spawn_req_in = 1'b0;
    checks++;
    if (spawn_ack_out !== 1'b1 || slotOf(2) !== {2'b11, 11'd1023, 2'b11, 1'b1}) begin
      errors++;
      $display("[TB] FAIL scan_deferred_spawn got ack %b slot %h want ack 1 slot %h",
               spawn_ack_out, slotOf(2), {2'b11, 11'd1023, 2'b11, 1'b1});
    end
    step();
  endtask

  task automatic test_retire();
    bit ok;
    game_reset_in = 1'b1;
    step();
    game_reset_in = 1'b0;
    doSpawn(2'd0, 2'd0, ok);
    repeat (68) doTick(4'd15);
    checks++;
    if (!ok || slotOf(0) !== {2'b00, 11'd3, 2'b00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL retire_pos3 got %h want %h", slotOf(0), {2'b00, 11'd3, 2'b00, 1'b1});
    end
    doTick(4'd0);
    checks++;
    if (slotOf(0) !== {2'b00, 11'd3, 2'b00, 1'b1} || retired_count_out !== 8'd0) begin
      errors++;
      $display("[TB] FAIL retire_speed0 got slot %h count %0d want slot %h count 0",
               slotOf(0), retired_count_out, {2'b00, 11'd3, 2'b00, 1'b1});
    end
    doTick(4'd5);
    checks++;
    if (slotOf(0) !== 16'h0000 || retired_count_out !== 8'd1) begin
      errors++;
      $display("[TB] FAIL retire_below got slot %h count %0d want slot 0000 count 1",
               slotOf(0), retired_count_out);
    end
    doSpawn(2'd1, 2'd2, ok);
    repeat (67) doTick(4'd15);
    doTick(4'd13);
    checks++;
    if (!ok || slotOf(0) !== {2'b01, 11'd5, 2'b10, 1'b1}) begin
      errors++;
      $display("[TB] FAIL retire_pos5 got %h want %h", slotOf(0), {2'b01, 11'd5, 2'b10, 1'b1});
    end
    doTick(4'd5);
    checks++;
    if (slotOf(0) !== 16'h0000 || retired_count_out !== 8'd2) begin
      errors++;
      $display("[TB] FAIL retire_equal got slot %h count %0d want slot 0000 count 2",
               slotOf(0), retired_count_out);
    end
  endtask

  task automatic test_full();
    bit ok;
    bit allOk;
    bit sawAck;
    int n;
    allOk = 1'b1;
    game_reset_in = 1'b1;
    step();
    game_reset_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      doSpawn(2'd0, 2'd0, ok);
      allOk &= ok;
    end
    repeat (67) doTick(4'd15);
    doSpawn(2'd2, 2'd2, ok);
    allOk &= ok;
    doTick(4'd13);
    doTick(4'd5);
    checks++;
    if (slotOf(4) !== {2'b10, 11'd1005, 2'b10, 1'b1} || retired_count_out !== 8'd4 || slotOf(0) !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL full_setup got slot4 %h slot0 %h count %0d want %h 0000 4",
               slotOf(4), slotOf(0), retired_count_out, {2'b10, 11'd1005, 2'b10, 1'b1});
    end
    for (int i = 0; i < 4; i++) begin
      doSpawn(2'd0, 2'd0, ok);
      allOk &= ok;
    end
    repeat (66) doTick(4'd15);
    for (int i = 0; i < 5; i++) begin
      doSpawn(2'd3, 2'd1, ok);
      allOk &= ok;
    end
    checks++;
    if (!allOk || spawn_full_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL full_flag got full %b spawns_ok %b want 1 1", spawn_full_out, allOk);
    end
    spawn_type_in = 2'd1;
    spawn_lane_in = 2'd3;
    spawn_req_in  = 1'b1;
    sawAck = 1'b0;
    repeat (4) begin
      step();
      if (spawn_ack_out) sawAck = 1'b1;
    end
    checks++;
    if (sawAck) begin
      errors++;
      $display("[TB] FAIL full_held_no_ack got ack 1 want 0");
    end
    speed_in      = 4'd15;
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
    n = 0;
    for (int k = 0; k < 30; k++) begin
      step();
      n++;
      if (spawn_ack_out) break;
    end
    spawn_req_in = 1'b0;
    checks++;
    if (spawn_ack_out !== 1'b1 || n != NUM_SLOTS + 1) begin
      errors++;
      $display("[TB] FAIL full_late_ack got ack %b after %0d cycles want 1 after %0d",
               spawn_ack_out, n, NUM_SLOTS + 1);
    end
    checks++;
    if (slotOf(4) !== {2'b01, 11'd1023, 2'b11, 1'b1} || slotOf(0) !== {2'b00, 11'd18, 2'b00, 1'b1}
        || retired_count_out !== 8'd5) begin
      errors++;
      $display("[TB] FAIL full_refill got slot4 %h slot0 %h count %0d want %h %h 5", slotOf(4), slotOf(0),
               retired_count_out, {2'b01, 11'd1023, 2'b11, 1'b1}, {2'b00, 11'd18, 2'b00, 1'b1});
    end
    step();
  endtask

  task automatic test_overrun();
    speed_in      = 4'd5;
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
    repeat (2) step();
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
    repeat (7) step();
    checks++;
    if (frame_overrun_out !== 1'b1 || update_busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_flag got overrun %b busy %b want 1 0", frame_overrun_out, update_busy_out);
    end
    checks++;
    if (slotOf(0) !== {2'b00, 11'd13, 2'b00, 1'b1} || slotOf(9) !== {2'b11, 11'd1003, 2'b01, 1'b1}) begin
      errors++;
      $display("[TB] FAIL overrun_once got %h %h want %h %h", slotOf(0), slotOf(9),
               {2'b00, 11'd13, 2'b00, 1'b1}, {2'b11, 11'd1003, 2'b01, 1'b1});
    end
    step();
    checks++;
    if (update_busy_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL overrun_dropped got busy %b want 0", update_busy_out);
    end
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
    repeat (3) step();
    game_reset_in = 1'b1;
    step();
    game_reset_in = 1'b0;
    checks++;
    if (obstacles_out !== '0 || retired_count_out !== 8'd0 || frame_overrun_out !== 1'b0
        || update_busy_out !== 1'b0 || spawn_ack_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midscan_reset got table_nonzero %b count %0d overrun %b busy %b ack %b want 0 0 0 0 0",
               |obstacles_out, retired_count_out, frame_overrun_out, update_busy_out, spawn_ack_out);
    end
    repeat (2) step();
    enable_in     = 1'b0;
    frame_tick_in = 1'b1;
    spawn_req_in  = 1'b1;
    step();
    frame_tick_in = 1'b0;
    step();
    checks++;
    if (update_busy_out !== 1'b0 || spawn_ack_out !== 1'b0 || frame_overrun_out !== 1'b0
        || obstacles_out !== '0) begin
      errors++;
      $display("[TB] FAIL disabled_ignored got busy %b ack %b overrun %b table_nonzero %b want 0 0 0 0",
               update_busy_out, spawn_ack_out, frame_overrun_out, |obstacles_out);
    end
    spawn_req_in = 1'b0;
    enable_in    = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [5:0] ackSeq;
    spawn_type_in = 2'd1;
    spawn_lane_in = 2'd0;
    spawn_req_in  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      ackSeq[5-i] = spawn_ack_out;
    end
    spawn_req_in = 1'b0;
    checks++;
    if (ackSeq !== 6'b101010) begin
      errors++;
      $display("[TB] FAIL b2b_ack_pattern got %b want 101010", ackSeq);
    end
    checks++;
    if (slotOf(2) !== {2'b01, 11'd1023, 2'b00, 1'b1} || slotOf(3) !== 16'h0000) begin
      errors++;
      $display("[TB] FAIL b2b_slots got slot2 %h slot3 %h want %h 0000", slotOf(2), slotOf(3),
               {2'b01, 11'd1023, 2'b00, 1'b1});
    end
    spawn_req_in = 1'b1;
    step();
    spawn_req_in  = 1'b0;
    speed_in      = 4'd2;
    frame_tick_in = 1'b1;
    step();
    frame_tick_in = 1'b0;
    checks++;
    if (update_busy_out !== 1'b0 || spawn_ack_out !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pending_in_ack got busy %b ack %b want 0 0", update_busy_out, spawn_ack_out);
    end
    step();
    checks++;
    if (update_busy_out !== 1'b1) begin
      errors++;
      $display("[TB] FAIL pending_starts_scan got busy %b want 1", update_busy_out);
    end
    repeat (NUM_SLOTS) step();
    checks++;
    if (update_busy_out !== 1'b0 || slotOf(3) !== {2'b01, 11'd1021, 2'b00, 1'b1}
        || slotOf(0) !== {2'b01, 11'd1021, 2'b00, 1'b1}) begin
      errors++;
      $display("[TB] FAIL pending_scan_result got busy %b slot0 %h slot3 %h want 0 %h %h",
               update_busy_out, slotOf(0), slotOf(3), {2'b01, 11'd1021, 2'b00, 1'b1},
               {2'b01, 11'd1021, 2'b00, 1'b1});
    end
  endtask

  // Scenario sequence; each task leaves the DUT idle for the next one.
  initial begin
    test_reset();
    test_spawn();
    test_scan();
    test_retire();
    test_full();
    test_overrun();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
